// File: rtl/ad_frame_align_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ad_frame_align_pkg
//  Purpose  : Shared widths and FSM state codes for the ADC frame aligner.
//  Contents : AD_DATA_NBIT  - ADC word width
//             AD_CHN_NBIT   - channel index width
//             AD_SP_NBIT    - minimum width of the sample-delay counter
//             fa_state_t    - aligner FSM states (IDLE/HUNT/PRE/ACQ, 2-bit)
//  Revision : 1.0 - initial release
// ============================================================================
package ad_frame_align_pkg;

  localparam int AD_DATA_NBIT = 18;
  localparam int AD_CHN_NBIT  = 7;
  localparam int AD_SP_NBIT   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_PRE  = 2'd2,
    ST_ACQ  = 2'd3
  } fa_state_t;

endpackage
`default_nettype wire

// File: rtl/ad_frame_align_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : ad_frame_align_sync_edge
//  Purpose  : Two-flop synchroniser for an asynchronous level plus a rise
//             detector on the synchronised level.
//  Ports    : mclk    in  - clock
//             rst     in  - synchronous reset, active-high
//             async_i in  - asynchronous input level
//             rise_o  out - high for one cycle after a synchronised 0->1
//  Revision : 1.0 - initial release
// ============================================================================
module ad_frame_align_sync_edge (
  input  logic mclk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge mclk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule
`default_nettype wire

// File: rtl/ad_frame_align.sv
`default_nettype none
// ============================================================================
//  Module   : ad_frame_align
//  Purpose  : Locks onto the frame-sync preamble and picks one ADC word per
//             sample-clock slot, emitting a channel-tagged sample stream with
//             sop/eop markers for the sample cache.
//  Ports    : mclk, rst          - clock, synchronous active-high reset
//             en                 - acquisition enable
//             sync, spclk        - asynchronous frame sync / sample clock
//             ad_data            - registered ADC word (quasi-static)
//             out_vd/chn/data    - one-cycle sample strobe, channel, sample
//             out_sop/out_eop    - first / last channel markers
//             frame_err          - one-cycle pulse on a malformed frame
//             locked             - high while acquiring a frame
//             frame_cnt, err_cnt - good-frame / error counters, present only
//                                  when AD_FRAME_STAT_EN is defined
//  Revision : 1.0 - initial release
// ============================================================================
module ad_frame_align
  import ad_frame_align_pkg::*;
#(
  parameter int DATA_NBIT    = AD_DATA_NBIT,
  parameter int CHN_NUM      = 128,
  parameter int CHN_NBIT     = AD_CHN_NBIT,
  parameter int MIN_SYNC_LEN = 8,
  parameter int SAMPLE_DLY   = 20
) (
  input  logic                 mclk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sync,
  input  logic                 spclk,
  input  logic [DATA_NBIT-1:0] ad_data,
  output logic                 out_vd,
  output logic [CHN_NBIT-1:0]  out_chn,
  output logic [DATA_NBIT-1:0] out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic                 frame_err,
`ifdef AD_FRAME_STAT_EN
  output logic [15:0]          frame_cnt,
  output logic [15:0]          err_cnt,
`endif
  output logic                 locked
);

  localparam int PRE_NBIT     = $clog2(MIN_SYNC_LEN + 1);
  localparam int DLY_NBIT_MIN = $clog2(SAMPLE_DLY + 1);
  localparam int DLY_NBIT     = (DLY_NBIT_MIN > AD_SP_NBIT) ? DLY_NBIT_MIN : AD_SP_NBIT;

  localparam logic [PRE_NBIT-1:0] PRE_MIN  = PRE_NBIT'(MIN_SYNC_LEN);
  localparam logic [DLY_NBIT-1:0] DLY_LOAD = DLY_NBIT'(SAMPLE_DLY);
  localparam logic [CHN_NBIT-1:0] CHN_LAST = CHN_NBIT'(CHN_NUM - 1);

  logic                 sp_rise;
  logic                 sync_s1_q, sync_s2_q;

  fa_state_t            state_q, state_d;
  logic [PRE_NBIT-1:0]  pre_cnt_q, pre_cnt_d;
  logic [DLY_NBIT-1:0]  dly_cnt_q, dly_cnt_d;
  logic [CHN_NBIT-1:0]  chn_q, chn_d;
  logic                 out_vd_q, out_vd_d;
  logic [CHN_NBIT-1:0]  out_chn_q, out_chn_d;
  logic [DATA_NBIT-1:0] out_data_q, out_data_d;
  logic                 out_sop_q, out_sop_d;
  logic                 out_eop_q, out_eop_d;
  logic                 frame_err_q, frame_err_d;

  ad_frame_align_sync_edge u_spclk_sync (
    .mclk    (mclk),
    .rst     (rst),
    .async_i (spclk),
    .rise_o  (sp_rise)
  );

  // sync uses the same two-flop depth as spclk, so sync_s2_q is the sync
  // level that belongs to the spclk rise currently flagged by sp_rise.
  always_ff @(posedge mclk) begin
    if (rst) begin
      sync_s1_q   <= 1'b0;
      sync_s2_q   <= 1'b0;
      state_q     <= ST_IDLE;
      pre_cnt_q   <= '0;
      dly_cnt_q   <= '0;
      chn_q       <= '0;
      out_vd_q    <= 1'b0;
      out_chn_q   <= '0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_s1_q   <= sync;
      sync_s2_q   <= sync_s1_q;
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      dly_cnt_q   <= dly_cnt_d;
      chn_q       <= chn_d;
      out_vd_q    <= out_vd_d;
      out_chn_q   <= out_chn_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      frame_err_q <= frame_err_d;
    end
  end

  // dly_cnt_q != 0 means a pick is pending; the word is taken when it is 1,
  // so out_vd appears SAMPLE_DLY+1 cycles after the arming sp_rise.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    chn_d       = chn_q;
    dly_cnt_d   = (dly_cnt_q != '0) ? dly_cnt_q - DLY_NBIT'(1) : '0;
    out_vd_d    = 1'b0;
    out_chn_d   = out_chn_q;
    out_data_d  = out_data_q;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dly_cnt_d = '0;
        if (en) state_d = ST_HUNT;
      end
      ST_HUNT: begin
        dly_cnt_d = '0;
        if (sp_rise && sync_s2_q) begin
          state_d   = ST_PRE;
          pre_cnt_d = PRE_NBIT'(1);
        end
      end
      ST_PRE: begin
        dly_cnt_d = '0;
        if (sp_rise) begin
          if (sync_s2_q) begin
            if (pre_cnt_q != '1) pre_cnt_d = pre_cnt_q + PRE_NBIT'(1);
          end else if (pre_cnt_q >= PRE_MIN) begin
            // The rise that ends the preamble is channel slot 0.
            state_d   = ST_ACQ;
            chn_d     = '0;
            dly_cnt_d = DLY_LOAD;
          end else begin
            state_d     = ST_HUNT;
            frame_err_d = 1'b1;
          end
        end
      end
      ST_ACQ: begin
        if (sp_rise) begin
          if (sync_s2_q) begin
            // New preamble inside a frame: abort this one, count its start.
            state_d     = ST_PRE;
            pre_cnt_d   = PRE_NBIT'(1);
            dly_cnt_d   = '0;
            frame_err_d = 1'b1;
          end else if (dly_cnt_q != '0) begin
            // Slot arrived before the previous pick: slots cannot be trusted.
            state_d     = ST_HUNT;
            dly_cnt_d   = '0;
            frame_err_d = 1'b1;
          end else begin
            dly_cnt_d = DLY_LOAD;
          end
        end else if (dly_cnt_q == DLY_NBIT'(1)) begin
          out_vd_d   = 1'b1;
          out_chn_d  = chn_q;
          out_data_d = ad_data;
          out_sop_d  = (chn_q == '0);
          out_eop_d  = (chn_q == CHN_LAST);
          if (chn_q == CHN_LAST) begin
            chn_d   = '0;
            state_d = ST_HUNT;
          end else begin
            chn_d = chn_q + CHN_NBIT'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!en) begin
      state_d     = ST_IDLE;
      dly_cnt_d   = '0;
      out_vd_d    = 1'b0;
      out_chn_d   = out_chn_q;
      out_data_d  = out_data_q;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  assign out_vd    = out_vd_q;
  assign out_chn   = out_chn_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign frame_err = frame_err_q;
  assign locked    = (state_q == ST_ACQ);

`ifdef AD_FRAME_STAT_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge mclk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (out_eop_q) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (frame_err_q && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ad_frame_align.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ad_frame_align
//  Purpose  : Self-checking bench for ad_frame_align. A table of frame
//             records (preamble length, data slots, en/rst events, expected
//             sample/eop/error counts) is driven slot by slot; every sample
//             strobe is checked against the slot-number data pattern.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ad_frame_align;

  localparam int DW      = 18;
  localparam int CW      = 7;
  localparam int SP_HALF = 14;   // spclk half period in mclk cycles

  logic          mclk = 1'b0;
  logic          rst;
  logic          en;
  logic          sync;
  logic          spclk;
  logic [DW-1:0] ad_data;
  logic          out_vd;
  logic [CW-1:0] out_chn;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic          frame_err;
  logic          locked;
`ifdef AD_FRAME_STAT_EN
  logic [15:0]   frame_cnt;
  logic [15:0]   err_cnt;
`endif

  always #5 mclk = ~mclk;

  ad_frame_align dut (
    .mclk      (mclk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .spclk     (spclk),
    .ad_data   (ad_data),
    .out_vd    (out_vd),
    .out_chn   (out_chn),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .frame_err (frame_err),
`ifdef AD_FRAME_STAT_EN
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt),
`endif
    .locked    (locked)
  );

  typedef struct {
    int pre;      // slots with sync high
    int ndata;    // slots with sync low after the preamble
    int gap;      // trailing idle slots
    int en_off;   // data slot at which en drops (-1 none)
    int en_on;    // data slot at which en returns (-1 none)
    int rst_at;   // data slot during which rst pulses (-1 none)
    int exp_vd;
    int exp_eop;
    int exp_err;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int tot_vd   = 0;
  int tot_eop  = 0;
  int tot_err  = 0;
  int vd_snap  = 0;
  int base     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One mclk cycle; samples outputs on the falling edge.
  task automatic tick();
    int c;
    @(negedge mclk);
    if (out_vd === 1'b1) begin
      c = tot_vd - vd_snap;
      chk("vd_chn", out_chn, c);
      chk("vd_data", out_data, base + c);
      chk("vd_sop", out_sop, (c == 0));
      chk("vd_eop", out_eop, (c == 127));
      if (c != 127) chk("vd_locked", locked, 1);
      tot_vd++;
    end
    if (out_eop === 1'b1) tot_eop++;
    if (frame_err === 1'b1) tot_err++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vd"}, out_vd, 0);
    chk({tag, "_chn"}, out_chn, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_sop"}, out_sop, 0);
    chk({tag, "_eop"}, out_eop, 0);
    chk({tag, "_err"}, frame_err, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  task automatic drive_frame(input vec_t v);
    int eop0, err0, ds;
    vd_snap = tot_vd;
    eop0    = tot_eop;
    err0    = tot_err;
    base    = v.pre;
    for (int s = 0; s < v.pre + v.ndata + v.gap; s++) begin
      ds      = s - v.pre;
      spclk   = 1'b1;
      sync    = (s < v.pre);
      ad_data = DW'(s);
      if (v.en_off >= 0 && ds == v.en_off) en = 1'b0;
      if (v.en_on  >= 0 && ds == v.en_on)  en = 1'b1;
      for (int k = 0; k < SP_HALF; k++) begin
        if (v.rst_at >= 0 && ds == v.rst_at && k == 10) rst = 1'b1;
        tick();
        if (v.rst_at >= 0 && ds == v.rst_at && k == 10) begin
          chk_zero("rst_mid");
          rst = 1'b0;
        end
        if (v.en_off >= 0 && ds == v.en_off && k == 0) begin
          chk("en_off_vd", out_vd, 0);
          chk("en_off_locked", locked, 0);
        end
      end
      spclk = 1'b0;
      repeat (SP_HALF) tick();
    end
    chk("frame_vd_count", tot_vd - vd_snap, v.exp_vd);
    chk("frame_eop_count", tot_eop - eop0, v.exp_eop);
    chk("frame_err_count", tot_err - err0, v.exp_err);
  endtask

  vec_t vecs[9];
`ifdef AD_FRAME_STAT_EN
  vec_t good_v;
  vec_t bad_v;
`endif

  initial begin
    //          pre ndata gap en_off en_on rst_at  vd eop err
    vecs[0] = '{9, 128, 3, -1, -1, -1, 128, 1, 0}; // model frame
    vecs[1] = '{5,  10, 3, -1, -1, -1,   0, 0, 1}; // short preamble
    vecs[2] = '{9, 128, 3, -1, -1, -1, 128, 1, 0}; // relock
    vecs[3] = '{9,  60, 0, -1, -1, -1,  60, 0, 0}; // cut by next preamble
    vecs[4] = '{9, 128, 3, -1, -1, -1, 128, 1, 1}; // error at its first slot
    vecs[5] = '{9, 128, 3, 40, 80, -1,  40, 0, 0}; // en drop at chn 40
    vecs[6] = '{9, 128, 3, -1, -1, -1, 128, 1, 0};
    vecs[7] = '{9, 128, 3, -1, -1, 50,  50, 0, 0}; // rst mid-ACQ
    vecs[8] = '{9, 128, 3, -1, -1, -1, 128, 1, 0};

    rst = 1'b1; en = 1'b0; sync = 1'b0; spclk = 1'b0; ad_data = '0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    en  = 1'b1;
    repeat (5) tick();
    chk("hunt_locked", locked, 0);

    for (int i = 0; i < 9; i++) drive_frame(vecs[i]);

`ifdef AD_FRAME_STAT_EN
    good_v = '{9, 128, 3, -1, -1, -1, 128, 1, 0};
    bad_v  = '{5,  10, 3, -1, -1, -1,   0, 0, 1};
    rst = 1'b1;
    tick();
    chk("stat_rst_frames", frame_cnt, 0);
    chk("stat_rst_errs", err_cnt, 0);
    rst = 1'b0;
    repeat (5) tick();
    drive_frame(good_v);
    drive_frame(bad_v);
    drive_frame(good_v);
    drive_frame(bad_v);
    drive_frame(good_v);
    chk("stat_frame_cnt", frame_cnt, 3);
    chk("stat_err_cnt", err_cnt, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
